// File: rtl/fifo_pkg.sv
// Shared constants, payload type and sizing helper for the synchronous FIFO.
package fifo_pkg;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF      = 16;
    localparam int unsigned AFULL_LVL_DEF  = 12;
    localparam int unsigned AEMPTY_LVL_DEF = 4;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one write port, one synchronous read port.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset so a RAM macro can replace it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-address write in this cycle is not visible: old contents are read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer/count control, status flags and error pulse
// around a fifo_mem storage array.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned AFULL_LVL  = AFULL_LVL_DEF,
    parameter int unsigned AEMPTY_LVL = AEMPTY_LVL_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  full,
    output logic                  amst_empty,
    output logic                  amst_full,
    output logic                  error
);
    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic wr_acc_c;
    logic rd_acc_c;
    logic ovf_c;
    logic udf_c;

    // Accept/reject decisions; a full FIFO still takes a write alongside a read.
    always_comb begin
        wr_acc_c = 1'b0;
        rd_acc_c = 1'b0;
        ovf_c    = 1'b0;
        udf_c    = 1'b0;
        wr_acc_c = write_en && (!full || read_en);
        rd_acc_c = read_en && !empty;
        ovf_c    = write_en && full && !read_en;
        udf_c    = read_en && empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            error  <= 1'b0;
        end else begin
            error <= ovf_c || udf_c;
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Status flags decode only the registered count.
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign amst_empty = (count <= CNT_W'(AEMPTY_LVL));
    assign amst_full  = (count >= CNT_W'(AFULL_LVL));

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc_c),
        .waddr (wr_ptr),
        .wdata (wdata),
        .re    (rd_acc_c),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

`ifndef SYNTHESIS
    a_not_full_and_empty : assert property (@(posedge clk) disable iff (!rst)
        !(full && empty));
    a_count_range : assert property (@(posedge clk) disable iff (!rst)
        count <= CNT_W'(DEPTH));
    a_ctrl_known : assert property (@(posedge clk) disable iff (!rst)
        !$isunknown({write_en, read_en}));
    a_error_pulse : assert property (@(posedge clk) disable iff (!rst)
        (error && $past(error)) |-> $past(ovf_c || udf_c));
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int unsigned DW  = DATA_WIDTH_DEF;
    localparam int unsigned DEP = DEPTH_DEF;
    localparam int unsigned AFL = AFULL_LVL_DEF;
    localparam int unsigned AEL = AEMPTY_LVL_DEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_en;
    logic [DW-1:0] wdata;
    logic          read_en;
    logic [DW-1:0] rdata;
    logic          empty;
    logic          full;
    logic          amst_empty;
    logic          amst_full;
    logic          error;

    int checks = 0;
    int errors = 0;

    data_t q[$];
    data_t exp_rdata = '0;
    logic  exp_err   = 1'b0;

    sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .AFULL_LVL  (AFL),
        .AEMPTY_LVL (AEL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .wdata      (wdata),
        .read_en    (read_en),
        .rdata      (rdata),
        .empty      (empty),
        .full       (full),
        .amst_empty (amst_empty),
        .amst_full  (amst_full),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".rdata"},      rdata,              exp_rdata);
        chk({tag, ".empty"},      DW'(empty),         DW'(n == 0));
        chk({tag, ".full"},       DW'(full),          DW'(n == int'(DEP)));
        chk({tag, ".amst_empty"}, DW'(amst_empty),    DW'(n <= int'(AEL)));
        chk({tag, ".amst_full"},  DW'(amst_full),     DW'(n >= int'(AFL)));
        chk({tag, ".error"},      DW'(error),         DW'(exp_err));
    endtask

    // One clock: apply request, advance the model by the FIFO rules, then compare.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re, input string tag);
        bit is_full, is_empty;
        write_en = we;
        wdata    = wd;
        read_en  = re;
        is_full  = (q.size() == int'(DEP));
        is_empty = (q.size() == 0);
        exp_err  = (we && is_full && !re) || (re && is_empty);
        if (re && !is_empty) exp_rdata = q.pop_front();
        if (we && (!is_full || re)) q.push_back(wd);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst      = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        wdata    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all("in_reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("after_release");
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b0, "idle0");
        step(1'b0, '0, 1'b0, "idle1");

        // Ordered fill and drain: 0x01..0x10.
        for (int i = 1; i <= int'(DEP); i++) step(1'b1, DW'(i), 1'b0, $sformatf("fill%0d", i));
        for (int i = 1; i <= int'(DEP); i++) step(1'b0, '0, 1'b1, $sformatf("drain%0d", i));

        // Overflow on a full FIFO.
        for (int i = 0; i < int'(DEP); i++) step(1'b1, DW'($urandom), 1'b0, "ofill");
        step(1'b1, 8'hAA, 1'b0, "overflow");
        step(1'b0, '0, 1'b0, "overflow_clear");
        for (int i = 0; i < int'(DEP); i++) step(1'b0, '0, 1'b1, "odrain");

        // Underflow on an empty FIFO.
        step(1'b0, '0, 1'b1, "underflow");
        step(1'b0, '0, 1'b0, "underflow_clear");

        // Simultaneous read and write while full.
        for (int i = 0; i < int'(DEP); i++) step(1'b1, DW'(8'h80 + i), 1'b0, "sfill");
        step(1'b1, 8'h55, 1'b1, "rw_full");
        for (int i = 0; i < int'(DEP); i++) step(1'b0, '0, 1'b1, $sformatf("sdrain%0d", i));
        chk("last_is_55", rdata, 8'h55);

        // Simultaneous read and write while empty.
        step(1'b1, 8'h3C, 1'b1, "rw_empty");
        step(1'b0, '0, 1'b1, "rw_empty_rd");

        // Random traffic including wrap-around and boundary hits.
        for (int i = 0; i < 400; i++) begin
            step(1'b1 && ($urandom_range(0, 99) < 55), DW'($urandom),
                 $urandom_range(0, 99) < 45, "rand");
        end
        while (q.size() != 0) step(1'b0, '0, 1'b1, "rand_drain");

        // Asynchronous reset mid-cycle with 10 entries stored.
        for (int i = 0; i < 10; i++) step(1'b1, DW'($urandom), 1'b0, "pre_rst");
        #3;
        rst      = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        q.delete();
        exp_rdata = '0;
        exp_err   = 1'b0;
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b1, "post_rst_underflow");
        step(1'b0, '0, 1'b0, "post_rst_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
